// File: rtl/seq_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seq_shifter                                                   |
// | Purpose  : Multi-cycle WIDTH-bit shifter. Moves the operand one bit per  |
// |            clock, left or right (logical/arithmetic), by a programmable  |
// |            amount, with carry-out, zero flag and start/busy/done.        |
// | Ports    : clk, rst        - clock, synchronous active-high reset        |
// |            start          - request; accepted in IDLE or DONE only      |
// |            A, AMT, LA, LR - operand, amount, arith-right, right/left    |
// |            ROT            - rotate select (SEQ_SHIFTER_ROTATE_EN only)  |
// |            Y, C, Z        - result, last bit shifted out, Y==0 flag     |
// |            busy, done     - in SHIFT state / one-cycle completion pulse |
// | Option   : `define SEQ_SHIFTER_ROTATE_EN adds the ROT port and rotates. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seq_shifter #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [AMT_W-1:0] AMT,
  input  logic             LA,
  input  logic             LR,
`ifdef SEQ_SHIFTER_ROTATE_EN
  input  logic             ROT,
`endif
  output logic [WIDTH-1:0] Y,
  output logic             C,
  output logic             Z,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_y,     w_y_nxt;
  logic             r_c,     w_c_nxt;
  logic             r_z,     w_z_nxt;
  logic [AMT_W-1:0] r_count, w_count_nxt;
  logic             r_la,    w_la_nxt;
  logic             r_lr,    w_lr_nxt;
  logic             r_rot,   w_rot_nxt;
  logic             w_rot_in;
  logic [WIDTH-1:0] w_y_step;
  logic             w_c_step;

`ifdef SEQ_SHIFTER_ROTATE_EN
  assign w_rot_in = ROT;
`else
  // Without the rotate option the mode bit is tied off and folds away.
  assign w_rot_in = 1'b0;
`endif

  // One shift/rotate step of the current result, using the latched mode.
  always_comb begin
    w_y_step = r_y;
    w_c_step = 1'b0;
    if (r_lr) begin
      w_c_step = r_y[0];
      if (r_rot) w_y_step = {r_y[0], r_y[WIDTH-1:1]};
      else       w_y_step = {r_la & r_y[WIDTH-1], r_y[WIDTH-1:1]};
    end else begin
      w_c_step = r_y[WIDTH-1];
      if (r_rot) w_y_step = {r_y[WIDTH-2:0], r_y[WIDTH-1]};
      else       w_y_step = {r_y[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state and datapath update; Z is only refreshed on entry to DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_y_nxt     = r_y;
    w_c_nxt     = r_c;
    w_z_nxt     = r_z;
    w_count_nxt = r_count;
    w_la_nxt    = r_la;
    w_lr_nxt    = r_lr;
    w_rot_nxt   = r_rot;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_y_nxt     = A;
          w_c_nxt     = 1'b0;
          w_count_nxt = AMT;
          w_la_nxt    = LA;
          w_lr_nxt    = LR;
          w_rot_nxt   = w_rot_in;
          if (AMT == '0) begin
            w_state_nxt = S_DONE;
            w_z_nxt     = (A == '0);
          end else begin
            w_state_nxt = S_SHIFT;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        w_y_nxt     = w_y_step;
        w_c_nxt     = w_c_step;
        w_count_nxt = r_count - AMT_W'(1);
        if (r_count == AMT_W'(1)) begin
          w_state_nxt = S_DONE;
          w_z_nxt     = (w_y_step == '0);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_y     <= '0;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
      r_count <= '0;
      r_la    <= 1'b0;
      r_lr    <= 1'b0;
      r_rot   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_y     <= w_y_nxt;
      r_c     <= w_c_nxt;
      r_z     <= w_z_nxt;
      r_count <= w_count_nxt;
      r_la    <= w_la_nxt;
      r_lr    <= w_lr_nxt;
      r_rot   <= w_rot_nxt;
    end
  end

  assign Y    = r_y;
  assign C    = r_c;
  assign Z    = r_z;
  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seq_shifter                                                |
// | Purpose  : Directed self-checking bench for seq_shifter (WIDTH=8).       |
// |            Expected results are queued when an operation is started and  |
// |            popped by a done monitor forked from the main sequence.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_seq_shifter;

  localparam int WIDTH = 8;
  localparam int AMT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [AMT_W-1:0] AMT;
  logic             LA, LR, ROT;
  logic [WIDTH-1:0] Y;
  logic             C, Z, busy, done;

  typedef struct {
    logic [WIDTH-1:0] y;
    logic             c;
    logic             z;
    int               cyc;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  seq_shifter #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .AMT   (AMT),
    .LA    (LA),
    .LR    (LR),
`ifdef SEQ_SHIFTER_ROTATE_EN
    .ROT   (ROT),
`endif
    .Y     (Y),
    .C     (C),
    .Z     (Z),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: apply the per-step rule AMT times starting from A with C=0.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input int amt,
                                 input logic la, input logic lr, input logic rot);
    exp_t e;
    e.y = a;
    e.c = 1'b0;
    for (int i = 0; i < amt; i++) begin
      if (lr) begin
        e.c = e.y[0];
        e.y = rot ? {e.y[0], e.y[WIDTH-1:1]} : {la & e.y[WIDTH-1], e.y[WIDTH-1:1]};
      end else begin
        e.c = e.y[WIDTH-1];
        e.y = rot ? {e.y[WIDTH-2:0], e.y[WIDTH-1]} : {e.y[WIDTH-2:0], 1'b0};
      end
    end
    e.z   = (e.y == '0);
    e.cyc = 0;
    return e;
  endfunction

  // Called at a negedge: start is sampled on the next posedge; returns at the
  // following negedge with start low and the operand inputs scrambled.
  task automatic start_op(input logic [WIDTH-1:0] a, input int amt, input logic la,
                          input logic lr, input logic rot, input bit push);
    exp_t e;
    A     = a;
    AMT   = AMT_W'(amt);
    LA    = la;
    LR    = lr;
    ROT   = rot;
    start = 1'b1;
    if (push) begin
      e     = model(a, amt, la, lr, rot);
      e.cyc = cyc + 1 + amt;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    A     = WIDTH'($urandom);
    AMT   = AMT_W'($urandom);
    LA    = 1'($urandom);
    LR    = 1'($urandom);
    ROT   = 1'($urandom);
    chk("busy_after_start", {31'd0, busy}, {31'd0, amt != 0});
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    AMT   = '0;
    LA    = 1'b0;
    LR    = 1'b0;
    ROT   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_Y", {24'd0, Y}, 32'h0);
    chk("rst_C", {31'd0, C}, 32'h0);
    chk("rst_Z", {31'd0, Z}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_done", {31'd0, done}, 32'h0);
    rst = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (done) begin
          exp_t e;
          chk("done_expected", {31'd0, q.size() != 0}, 32'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("res_Y", {24'd0, Y}, {24'd0, e.y});
            chk("res_C", {31'd0, C}, {31'd0, e.c});
            chk("res_Z", {31'd0, Z}, {31'd0, e.z});
            chk("done_cycle", cyc, e.cyc);
            chk("busy_in_done", {31'd0, busy}, 32'h0);
          end
        end
      end
    join_none

    @(negedge clk);
    start_op(8'h96, 1, 1'b0, 1'b0, 1'b0, 1'b1);   // Y=2C C=1
    drain();
    start_op(8'h96, 3, 1'b1, 1'b1, 1'b0, 1'b1);   // Y=F2 C=1
    drain();
    start_op(8'h96, 3, 1'b0, 1'b1, 1'b0, 1'b1);   // Y=12 C=1
    drain();
    start_op(8'h5A, 0, 1'b0, 1'b0, 1'b0, 1'b1);   // no busy, done next cycle
    drain();
    start_op(8'hFF, 10, 1'b0, 1'b0, 1'b0, 1'b1);  // Y=00 C=0 Z=1
    drain();
    start_op(8'h80, 15, 1'b1, 1'b1, 1'b0, 1'b1);  // arithmetic saturates to FF
    drain();
    start_op(8'h80, 8, 1'b0, 1'b1, 1'b0, 1'b1);   // logical right to 0, C=1
    drain();

    // Start ignored while busy, then back-to-back start in the DONE cycle.
    start_op(8'h3C, 5, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    A     = 8'hAA;
    AMT   = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk("done_seen_b2b", {31'd0, done}, 32'd1);
    start_op(8'hC3, 2, 1'b1, 1'b1, 1'b0, 1'b1);
    drain();

    // Reset in the middle of an operation: no done may follow.
    start_op(8'h3C, 6, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_Y", {24'd0, Y}, 32'h0);
    chk("midrst_C", {31'd0, C}, 32'h0);
    chk("midrst_busy", {31'd0, busy}, 32'h0);
    chk("midrst_done", {31'd0, done}, 32'h0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst_queue", q.size(), 0);

`ifdef SEQ_SHIFTER_ROTATE_EN
    start_op(8'h81, 1, 1'b1, 1'b0, 1'b1, 1'b1);   // Y=03 C=1
    drain();
    start_op(8'h81, 9, 1'b1, 1'b1, 1'b1, 1'b1);   // Y=C0 C=1
    drain();
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Parametrised, multi-cycle successor to the team's 8-bit combinational single-step shifter.
- Shifts a WIDTH-bit operand left or right by a programmable amount AMT, one bit position per clock.
- Supports logical or arithmetic right shift and produces a carry-out and a zero flag.
- Start/busy/done handshake; used by game-logic datapaths (e.g. mine-bitmap row scans) that need shift-by-N without a full barrel shifter.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).
- AMT_W, 4, width of the shift-amount port; amounts 0 .. 2^AMT_W-1 are legal, including amounts > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only while busy=0.
- A  input  WIDTH  operand; captured on an accepted start.
- AMT  input  AMT_W  shift amount; captured on an accepted start.
- LA  input  1  1 = arithmetic right shift (sign fill), 0 = logical; ignored for left shifts; captured on start.
- LR  input  1  1 = shift right, 0 = shift left; captured on start.
- Y  output  WIDTH  result register.
- C  output  1  carry: last bit shifted out.
- Z  output  1  1 when Y == 0; valid with done.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse when Y/C/Z are final.

Behaviour:
- Reset: Y=0, C=0, Z=0, busy=0, done=0, state=IDLE, count=0. Reset overrides any in-progress operation, including start asserted in the same cycle.
- FSM states: IDLE, SHIFT, DONE. busy=1 only in SHIFT. done=1 only in DONE.
- IDLE or DONE with start=1 (cycle T): load Y<=A, C<=0, count<=AMT, and latch LA/LR.
  - If AMT=0, go to DONE at T+1.
  - Otherwise go to SHIFT at T+1.
- IDLE or DONE with start=0: go or stay in IDLE. Y, C, Z hold their values.
- SHIFT, one step per cycle, with count decremented each step:
  - Left step: Y <= {Y[WIDTH-2:0],0}, C <= Y[WIDTH-1].
  - Right step: Y <= {LA ? Y[WIDTH-1] : 0, Y[WIDTH-1:1]}, C <= Y[0].
  - When the step that moves count from 1 to 0 completes, go to DONE.
- Latency: AMT>0 occupies SHIFT for cycles T+1..T+AMT, with done high at T+AMT+1. AMT=0 gives done at T+1.
- Z is registered and updated on entry to DONE as (final Y == 0). It is held until the next done.
- start while busy=1 is ignored: no queueing, and the latched operands are unaffected.
- A start in the DONE cycle is accepted, giving back-to-back operations with done spacing of AMT+1 cycles.
- Y is visible during SHIFT but is only meaningful when done=1 or afterwards.
- Amounts >= WIDTH keep shifting:
  - Left and logical-right results reach all zeros.
  - Arithmetic right saturates to all copies of the sign bit.
  - C follows the per-step rule (0 once zeros are shifted out; the sign bit for arithmetic right).
- Inputs A/AMT/LA/LR may change freely after the start cycle.

Optional Feature:
- Macro: SEQ_SHIFTER_ROTATE_EN.
- Defined: adds port ROT (input, 1, captured on start). ROT=1 selects rotate, and LA is ignored.
  - Rotate-left step: Y <= {Y[WIDTH-2:0],Y[WIDTH-1]}, C <= Y[WIDTH-1].
  - Rotate-right step: Y <= {Y[0],Y[WIDTH-1:1]}, C <= Y[0].
  - Timing and handshake are unchanged.
- Undefined: no ROT port; only shift modes exist.

Test Plan:
- WIDTH=8: A=0x96, LR=0, AMT=1, start at T -> busy at T+1, done at T+2 with Y=0x2C, C=1, Z=0.
- A=0x96, LR=1, LA=1, AMT=3 -> done at T+4, Y=0xF2, C=1. Same with LA=0 -> Y=0x12, C=1.
- A=0x5A, AMT=0 -> no busy cycle, done at T+1, Y=0x5A, C=0. Then A=0xFF, LR=0, AMT=10 -> done at T+11, Y=0x00, C=0, Z=1.
- Start with AMT=5, pulse start again with different A at T+2 -> ignored, done at T+6 with first result. Then start in the DONE cycle -> accepted back-to-back.
- Assert rst at T+2 of an AMT=6 operation -> next cycle Y=0, C=0, busy=0, done=0, and no later done pulse.
- With SEQ_SHIFTER_ROTATE_EN: A=0x81, ROT=1, LR=0, AMT=1 -> Y=0x03, C=1. A=0x81, ROT=1, LR=1, AMT=9 -> Y=0xC0, C=1.
